// File: rtl/delivery_game_uc_if.sv
// Control/status bundle between the delivery game controller and its datapath.
// master = controller side, slave = datapath / sensor side.
interface delivery_game_uc_if;
  logic       iniciar;
  logic       game_over;
  logic       velocity_ready;
  logic       velocity_timeout;
  logic       end_delay;

  logic       reset_fd;
  logic       reset_ultrasonico;
  logic       reset_delay;
  logic       reset_timeout;
  logic       count_map;
  logic       get_velocity;
  logic       conta_delay;
  logic       conta_timeout;
  logic       jogando;
  logic       fim_jogo;
  logic [3:0] db_estado;
  logic [2:0] db_falhas;

  modport master (
    input  iniciar, game_over, velocity_ready, velocity_timeout, end_delay,
    output reset_fd, reset_ultrasonico, reset_delay, reset_timeout,
    output count_map, get_velocity, conta_delay, conta_timeout,
    output jogando, fim_jogo, db_estado, db_falhas
  );

  modport slave (
    output iniciar, game_over, velocity_ready, velocity_timeout, end_delay,
    input  reset_fd, reset_ultrasonico, reset_delay, reset_timeout,
    input  count_map, get_velocity, conta_delay, conta_timeout,
    input  jogando, fim_jogo, db_estado, db_falhas
  );
endinterface

// File: rtl/delivery_game_uc.sv
// Moore control unit for the delivery game: sequences ultrasonic measurements,
// counts consecutive sensor timeouts and resets the sensor after MAX_TIMEOUTS of them.
module delivery_game_uc #(
  parameter int unsigned MAX_TIMEOUTS = 3
) (
  input logic                  clock,
  input logic                  reset,
  delivery_game_uc_if.master   bus
);

  if (MAX_TIMEOUTS < 1 || MAX_TIMEOUTS > 7) begin : g_bad_max_timeouts
    $error("delivery_game_uc: MAX_TIMEOUTS must be in 1..7");
  end

  localparam logic [2:0] MaxFails = 3'(MAX_TIMEOUTS);

  typedef enum logic [3:0] {
    StIdle         = 4'd0,
    StInicia       = 4'd1,
    StMede         = 4'd2,
    StEsperaMedida = 4'd3,
    StResetSensor  = 4'd4,
    StEsperaAtraso = 4'd5,
    StFim          = 4'd6
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] fail_q, fail_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      fail_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
    end
  end

  // Next state and fail count.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    unique case (state_q)
      StIdle: begin
        if (bus.iniciar) state_d = StInicia;
      end
      StInicia: begin
        fail_d  = 3'd0;
        state_d = StMede;
      end
      StMede: begin
        state_d = bus.game_over ? StFim : StEsperaMedida;
      end
      StEsperaMedida: begin
        if (bus.game_over) begin
          state_d = StFim;
        end else if (bus.velocity_ready) begin
          // A ready pulse wins over a simultaneous timeout.
          fail_d  = 3'd0;
          state_d = StEsperaAtraso;
        end else if (bus.velocity_timeout) begin
          if (fail_q + 3'd1 == MaxFails) begin
            // Count clears on entry so it never reaches MAX_TIMEOUTS on the output.
            fail_d  = 3'd0;
            state_d = StResetSensor;
          end else begin
            fail_d  = fail_q + 3'd1;
            state_d = StEsperaAtraso;
          end
        end
      end
      StResetSensor: begin
        fail_d  = 3'd0;
        state_d = bus.game_over ? StFim : StEsperaAtraso;
      end
      StEsperaAtraso: begin
        if (bus.game_over) begin
          state_d = StFim;
        end else if (bus.end_delay) begin
          state_d = StMede;
        end
      end
      StFim: begin
        if (bus.iniciar) state_d = StInicia;
      end
      default: begin
        fail_d  = 3'd0;
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs, decoded from the registered state only.
  always_comb begin
    bus.reset_fd          = 1'b0;
    bus.reset_ultrasonico = 1'b0;
    bus.reset_delay       = 1'b0;
    bus.reset_timeout     = 1'b0;
    bus.count_map         = 1'b0;
    bus.get_velocity      = 1'b0;
    bus.conta_delay       = 1'b0;
    bus.conta_timeout     = 1'b0;
    bus.jogando           = 1'b0;
    bus.fim_jogo          = 1'b0;
    unique case (state_q)
      StIdle: ;
      StInicia: begin
        bus.reset_fd          = 1'b1;
        bus.reset_ultrasonico = 1'b1;
        bus.reset_delay       = 1'b1;
        bus.reset_timeout     = 1'b1;
      end
      StMede: begin
        bus.get_velocity  = 1'b1;
        bus.reset_timeout = 1'b1;
        bus.reset_delay   = 1'b1;
        bus.count_map     = 1'b1;
        bus.jogando       = 1'b1;
      end
      StEsperaMedida: begin
        bus.count_map     = 1'b1;
        bus.conta_timeout = 1'b1;
        bus.jogando       = 1'b1;
      end
      StResetSensor: begin
        bus.reset_ultrasonico = 1'b1;
        bus.count_map         = 1'b1;
        bus.jogando           = 1'b1;
      end
      StEsperaAtraso: begin
        bus.count_map   = 1'b1;
        bus.conta_delay = 1'b1;
        bus.jogando     = 1'b1;
      end
      StFim: begin
        bus.fim_jogo = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.db_estado = state_q;
  assign bus.db_falhas = fail_q;

endmodule

// File: tb/tb_delivery_game_uc.sv
// Self-checking bench for delivery_game_uc: directed scenarios followed by random
// stimulus, all checked every cycle against a behavioural model.
module tb_delivery_game_uc;

  localparam int MaxTo = 3;

  logic clock;
  logic reset;

  delivery_game_uc_if bus ();

  delivery_game_uc #(
    .MAX_TIMEOUTS (MaxTo)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: state code and consecutive-timeout count as plain integers.
  int m_st   = 0;
  int m_f    = 0;
  logic prev_gv = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected {reset_fd, reset_ultrasonico, reset_delay, reset_timeout, count_map,
  //           get_velocity, conta_delay, conta_timeout, jogando, fim_jogo}
  function automatic logic [9:0] exp_ctrl(input int st);
    logic playing;
    playing = (st >= 2 && st <= 5);
    return {st == 1, st == 1 || st == 4, st == 1 || st == 2, st == 1 || st == 2,
            playing, st == 2, st == 5, st == 3, playing, st == 6};
  endfunction

  task automatic model_next();
    if (reset) begin
      m_st = 0;
      m_f  = 0;
    end else begin
      case (m_st)
        0: if (bus.iniciar) m_st = 1;
        1: begin m_st = 2; m_f = 0; end
        2: m_st = bus.game_over ? 6 : 3;
        3: begin
          if (bus.game_over) m_st = 6;
          else if (bus.velocity_ready) begin m_st = 5; m_f = 0; end
          else if (bus.velocity_timeout) begin
            if (m_f + 1 == MaxTo) begin m_st = 4; m_f = 0; end
            else begin m_st = 5; m_f = m_f + 1; end
          end
        end
        4: begin m_f = 0; m_st = bus.game_over ? 6 : 5; end
        5: if (bus.game_over) m_st = 6; else if (bus.end_delay) m_st = 2;
        6: if (bus.iniciar) m_st = 1;
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic step();
    logic [9:0] ctrl;
    model_next();
    @(posedge clock);
    #1;
    ctrl = {bus.reset_fd, bus.reset_ultrasonico, bus.reset_delay, bus.reset_timeout,
            bus.count_map, bus.get_velocity, bus.conta_delay, bus.conta_timeout,
            bus.jogando, bus.fim_jogo};
    check("db_estado", 32'(bus.db_estado), 32'(m_st));
    check("db_falhas", 32'(bus.db_falhas), 32'(m_f));
    check("ctrl", 32'(ctrl), 32'(exp_ctrl(m_st)));
    check("gv_twice", 32'(prev_gv & bus.get_velocity), 32'd0);
    prev_gv = bus.get_velocity;
  endtask

  task automatic clear_inputs();
    reset                = 1'b0;
    bus.iniciar          = 1'b0;
    bus.game_over        = 1'b0;
    bus.velocity_ready   = 1'b0;
    bus.velocity_timeout = 1'b0;
    bus.end_delay        = 1'b0;
  endtask

  // One measurement ending in a timeout: from state 3, back to state 3 via 5 and 2.
  task automatic timeout_round();
    bus.velocity_timeout = 1'b1; step(); bus.velocity_timeout = 1'b0;
    bus.end_delay = 1'b1; step(); bus.end_delay = 1'b0;
    step();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    check("rst_estado", 32'(bus.db_estado), 32'd0);
    reset = 1'b0;

    // Start sequence 0 -> 1 -> 2 -> 3.
    bus.iniciar = 1'b1; step(); bus.iniciar = 1'b0;
    check("start_rst_fd", 32'(bus.reset_fd), 32'd1);
    step();
    check("mede_gv", 32'(bus.get_velocity), 32'd1);
    step();
    check("espera_estado", 32'(bus.db_estado), 32'd3);

    // Successful measurement, then delay end.
    bus.velocity_ready = 1'b1; step(); bus.velocity_ready = 1'b0;
    check("ok_estado", 32'(bus.db_estado), 32'd5);
    bus.end_delay = 1'b1; step(); bus.end_delay = 1'b0;
    check("redo_gv", 32'(bus.get_velocity), 32'd1);
    step();

    // Consecutive timeouts up to the sensor reset.
    timeout_round();
    check("falhas1", 32'(bus.db_falhas), 32'd1);
    timeout_round();
    check("falhas2", 32'(bus.db_falhas), 32'd2);
    bus.velocity_timeout = 1'b1; step(); bus.velocity_timeout = 1'b0;
    check("rs_estado", 32'(bus.db_estado), 32'd4);
    check("rs_pulse", 32'(bus.reset_ultrasonico), 32'd1);
    check("rs_falhas", 32'(bus.db_falhas), 32'd0);
    step();
    check("rs_one_cycle", 32'(bus.reset_ultrasonico), 32'd0);

    // Ready and timeout together count as success.
    bus.end_delay = 1'b1; step(); bus.end_delay = 1'b0;
    step();
    bus.velocity_ready = 1'b1; bus.velocity_timeout = 1'b1; step();
    bus.velocity_ready = 1'b0; bus.velocity_timeout = 1'b0;
    check("both_estado", 32'(bus.db_estado), 32'd5);

    // Game over from the delay state, then restart.
    bus.game_over = 1'b1; step(); bus.game_over = 1'b0;
    check("fim_jogo", 32'(bus.fim_jogo), 32'd1);
    check("fim_map", 32'(bus.count_map), 32'd0);
    bus.iniciar = 1'b1; step(); bus.iniciar = 1'b0;
    check("restart", 32'(bus.db_estado), 32'd1);
    step(); step();

    // Reset mid-measurement with two failures pending.
    timeout_round();
    timeout_round();
    reset = 1'b1; step(); reset = 1'b0;
    check("midrst_estado", 32'(bus.db_estado), 32'd0);
    check("midrst_jogando", 32'(bus.jogando), 32'd0);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      reset                = ($urandom_range(63) == 0);
      bus.iniciar          = ($urandom_range(7) == 0);
      bus.game_over        = ($urandom_range(40) == 0);
      bus.velocity_ready   = ($urandom_range(5) == 0);
      bus.velocity_timeout = ($urandom_range(3) == 0);
      bus.end_delay        = ($urandom_range(3) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/delivery_game_uc.md
DELIVERY_GAME_UC -- requirements
Module: delivery_game_uc

Interface
REQ-001 Parameter MAX_TIMEOUTS, default 3, SHALL set the number of consecutive sensor timeouts that force a sensor reset; legal range 1..7.
REQ-002 clock  in  1  system clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 iniciar  in  1  start/restart request, level-sampled.
REQ-005 game_over  in  1  collision flag from the game datapath.
REQ-006 velocity_ready  in  1  ultrasonic measurement done pulse.
REQ-007 velocity_timeout  in  1  measurement timeout counter end.
REQ-008 end_delay  in  1  inter-measurement delay counter end.
REQ-009 reset_fd, reset_ultrasonico, reset_delay, reset_timeout  out  1 each  datapath, sensor, delay counter and timeout counter clears.
REQ-010 count_map, get_velocity, conta_delay, conta_timeout  out  1 each  map advance enable, measure request, delay count enable, timeout count enable.
REQ-011 jogando  out  1  game active; fim_jogo  out  1  game-over indication.
REQ-012 db_estado  out  4  state code; db_falhas  out  3  consecutive-timeout count.

Function
REQ-013 The block SHALL be a Moore FSM; every output SHALL be a function of state and registered fail count only.
REQ-014 The state codes SHALL be: IDLE=0, INICIA=1, MEDE=2, ESPERA_MEDIDA=3, RESET_SENSOR=4, ESPERA_ATRASO=5, FIM=6; db_estado SHALL equal the code.
REQ-015 IDLE: all control outputs SHALL be 0; iniciar=1 -> INICIA, else stay.
REQ-016 INICIA: reset_fd, reset_ultrasonico, reset_delay and reset_timeout SHALL be 1; fail count SHALL clear; next state MEDE unconditionally.
REQ-017 MEDE: get_velocity=1, reset_timeout=1, reset_delay=1, count_map=1 for exactly one cycle; next state ESPERA_MEDIDA, unless game_over=1 -> FIM.
REQ-018 ESPERA_MEDIDA: count_map=1, conta_timeout=1; transitions in priority order: game_over -> FIM; velocity_ready -> ESPERA_ATRASO with fail count cleared; velocity_timeout -> fail count +1, then RESET_SENSOR if new count = MAX_TIMEOUTS, else ESPERA_ATRASO; otherwise stay.
REQ-019 velocity_ready and velocity_timeout in the same cycle SHALL be treated as a successful measurement.
REQ-020 RESET_SENSOR: reset_ultrasonico=1, count_map=1 for one cycle; fail count SHALL clear; next ESPERA_ATRASO, unless game_over -> FIM.
REQ-021 ESPERA_ATRASO: count_map=1, conta_delay=1; game_over -> FIM; end_delay -> MEDE; otherwise stay.
REQ-022 FIM: fim_jogo=1, all other control outputs 0; iniciar=1 -> INICIA; otherwise stay.
REQ-023 jogando SHALL be 1 exactly in states MEDE, ESPERA_MEDIDA, RESET_SENSOR and ESPERA_ATRASO.
REQ-024 The fail count SHALL never exceed MAX_TIMEOUTS and SHALL not wrap.
REQ-025 Unused state encodings SHALL go to IDLE on the next clock, with all outputs 0.
REQ-026 get_velocity SHALL never be 1 for two consecutive cycles.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE and fail count 0 from any state, including mid-measurement; all outputs SHALL be 0 the following cycle.
REQ-028 reset SHALL take priority over every other input.

Verification
REQ-029 reset, then iniciar=1 for 1 cycle -> db_estado 0->1->2->3; reset_fd=1 only in state 1; get_velocity=1 only in state 2.
REQ-030 In state 3, pulse velocity_ready -> state 5, db_falhas=0; end_delay pulse -> state 2 the next cycle with a single get_velocity pulse.
REQ-031 MAX_TIMEOUTS=3: three measurement cycles each ending in velocity_timeout -> db_falhas 1, 2, then state 4 with reset_ultrasonico=1 for one cycle, db_falhas=0.
REQ-032 velocity_ready and velocity_timeout both 1 in state 3 -> state 5, db_falhas unchanged at 0.
REQ-033 game_over=1 in state 5 -> state 6, fim_jogo=1, count_map=0; iniciar=1 -> state 1.
REQ-034 reset=1 while in state 3 with db_falhas=2 -> next cycle db_estado=0, db_falhas=0, all outputs 0.
